// File: rtl/serial_tx.sv
// Byte-to-serial transmitter: a small byte FIFO feeding a start/8-data(MSB first)/stop framer.
// Each bit is held for CLKS_PER_BIT clocks; the line idles high.
module serial_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] parallel_in,
   input  logic       load,
   output logic       ready,
   output logic       serial_out,
   output logic       tx_busy,
   output logic       char_sent
);

   // state | meaning
   // IDLE  | line high, waiting for a queued byte
   // START | driving the start bit (0)
   // DATA  | driving shift[bic], bic counts 7 down to 0
   // STOP  | driving the stop bit (1); pops the next byte with no idle gap
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   localparam int BSC_W = $clog2(CLKS_PER_BIT);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [BSC_W-1:0] BSC_MAX = BSC_W'(CLKS_PER_BIT - 1);

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [CNT_W-1:0] count;

   logic [1:0]       state, state_n;
   logic [BSC_W-1:0] bsc, bsc_n;
   logic [2:0]       bic, bic_n;
   logic [7:0]       shift, shift_n;
   logic             push, pop, bit_done, fifo_empty, sent_n, line_n;

   assign ready      = count < CNT_W'(FIFO_DEPTH);
   assign fifo_empty = (count == '0);
   assign push       = load && ready;
   assign bit_done   = (bsc == BSC_MAX);

   always_comb begin
      state_n = state;
      bsc_n   = bsc;
      bic_n   = bic;
      shift_n = shift;
      pop     = 1'b0;
      sent_n  = 1'b0;
      case (state)
         IDLE: begin
            bsc_n = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_n = mem[rptr];
               state_n = START;
            end
         end
         START: begin
            if (bit_done) begin
               bsc_n   = '0;
               bic_n   = 3'd7;
               state_n = DATA;
            end else begin
               bsc_n = bsc + 1'b1;
            end
         end
         DATA: begin
            if (bit_done) begin
               bsc_n = '0;
               if (bic == 3'd0) state_n = STOP;
               else             bic_n   = bic - 1'b1;
            end else begin
               bsc_n = bsc + 1'b1;
            end
         end
         STOP: begin
            if (bit_done) begin
               bsc_n  = '0;
               sent_n = 1'b1;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_n = mem[rptr];
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               bsc_n = bsc + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // The line is registered from the next state so it changes on the same edge as the state.
   always_comb begin
      line_n = 1'b1;
      case (state_n)
         START:   line_n = 1'b0;
         DATA:    line_n = shift_n[bic_n];
         default: line_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         bsc        <= '0;
         bic        <= '0;
         shift      <= '0;
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
         serial_out <= 1'b1;
         tx_busy    <= 1'b0;
         char_sent  <= 1'b0;
      end else begin
         state      <= state_n;
         bsc        <= bsc_n;
         bic        <= bic_n;
         shift      <= shift_n;
         serial_out <= line_n;
         tx_busy    <= (state_n != IDLE);
         char_sent  <= sent_n;
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && push) mem[wptr] <= parallel_in;
   end

endmodule

// File: doc/serial_tx.md
# serial_tx

Byte-to-serial transmitter with a small input FIFO; it drives the serial line that the team's 16x-oversampling receiver samples. It accepts bytes over a single-cycle `load` strobe, queues them, and serializes each one as a 10-bit frame: a start bit (0), 8 data bits MSB-first, and a stop bit (1). Each bit is held for `CLKS_PER_BIT` clocks. It sits between the host-side byte source and the physical serial line.

## Interface
- `CLKS_PER_BIT`, 16, clocks each serial bit is held (≥2)
- `FIFO_DEPTH`, 4, byte entries in the input FIFO (power of 2, ≥2)

- `clk`  input  1  clock
- `reset`  input  1  reset, synchronous, active-high
- `parallel_in`  input  8  byte to send; sampled when `load` && `ready`
- `load`  input  1  write strobe; one byte is accepted per cycle
- `ready`  output  1  FIFO not full (combinational from count: count < FIFO_DEPTH)
- `serial_out`  output  1  serial line, registered, idles high
- `tx_busy`  output  1  high whenever state ≠ IDLE, registered
- `char_sent`  output  1  one-cycle pulse when a stop bit completes, registered

## Operation
- States: IDLE, START, DATA, STOP.
- Counters:
  - bit-sample counter `bsc`: width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1.
  - bit index `bic`: 3 bits, counts 7 down to 0.
  - FIFO count: $clog2(FIFO_DEPTH)+1 bits.
- IDLE: `serial_out`=1. If the FIFO is non-empty at an edge: pop the head into a shift register, set `bsc`=0, go to START.
- START: `serial_out`=0. When `bsc`=CLKS_PER_BIT-1: set `bsc`=0 and `bic`=7, go to DATA.
- DATA: `serial_out` = shift[`bic`]. When `bsc` wraps:
  - if `bic`=0, go to STOP;
  - otherwise decrement `bic`.
- STOP: `serial_out`=1. When `bsc` wraps, pulse `char_sent`. Then:
  - if the FIFO is non-empty, pop and go straight to START (no idle gap);
  - otherwise go to IDLE.
- FIFO rules:
  - Push on `load` && `ready`. `load` with `ready`=0 is dropped silently; state is unchanged.
  - Push and pop in the same cycle: count is unchanged, both take effect.
  - A byte pushed into an empty FIFO cannot pop on that same edge. It pops on the next edge.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Reset, including mid-frame:
  - `serial_out`=1, `tx_busy`=0, `char_sent`=0, `ready`=1.
  - FIFO emptied, pointers and counters cleared, state IDLE.
  - A partial frame is abandoned. No `char_sent` is issued for it.
  - `load` is ignored in any cycle where `reset` is high.

## Timing
- Edge numbering: `load` sampled at edge 0 with the FIFO empty and state IDLE.
  - Pop occurs at edge 1; `serial_out` falls after edge 1.
- Frame layout:
  - start bit: edges 1–17;
  - data bit 7: edges 17–33;
  - …
  - data bit 0: edges 129–145;
  - stop bit: edges 145–161.
- At edge 161: `char_sent`=1 for exactly one cycle, and `tx_busy` drops unless another byte is queued.
- Frame length is 10×CLKS_PER_BIT clocks. Back-to-back frames are spaced exactly 10×CLKS_PER_BIT clocks apart.
- `tx_busy` rises after edge 1 and stays high continuously across back-to-back frames.
- `ready` reflects the FIFO count after each edge, with no extra delay.

## Test plan
- Reset: assert `reset` for 2 cycles.
  - Required: `serial_out`=1, `ready`=1, `tx_busy`=0, `char_sent`=0.
  - With no load, the line stays high for 500 cycles.
- Single byte 0xA5 loaded at edge 0.
  - Required line bits, 16 clocks each from edge 1: 0,1,0,1,0,0,1,0,1,1.
  - `char_sent` pulses once after edge 161; `tx_busy` is high from edges 1–161.
- Back-to-back: 0x00 at edge 0, 0xFF at edge 1.
  - Second start bit begins at edge 161 with no high gap.
  - `char_sent` pulses at edges 161 and 321; `tx_busy` never drops between them.
- Overflow: `load` on edges 0–5 with bytes 0x01..0x06.
  - `ready` goes low after edge 4 (count=4); 0x06 is dropped.
  - Exactly five frames are sent, 0x01..0x05 in order.
  - `ready` returns high after edge 1+160=161 pop.
- Reset mid-frame: load 0x3C, assert `reset` at edge 80 (inside DATA).
  - `serial_out`=1 next cycle; no `char_sent`; FIFO empty.
  - A fresh load of 0x81 then produces a correct frame with the edge-0/1 timing above.
- Loopback with `CLKS_PER_BIT`=16 into the receiver: send 0x00, 0x55, 0xC3, 0xFF.
  - The receiver reports each byte exactly once, in order.
